// File: rtl/mem_readback.sv
// mem_readback: reads a contiguous, word-aligned range out of a
// synchronous-read data memory and streams each word with its byte address
// on a valid/ready interface. A 2-entry FIFO absorbs the one-cycle read
// latency, and reads are issued only when the FIFO has room for them.
module mem_readback #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] base_addr,
  input  logic [CNT_W-1:0] word_count,
  output logic [WIDTH-1:0] mem_addr,
  output logic             mem_re,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic [WIDTH-1:0] out_data,
  output logic [WIDTH-1:0] out_addr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             done,
  output logic             err_align
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t           state;
  logic [WIDTH-1:0] cur_addr;    // address of the next read to issue
  logic [WIDTH-1:0] last_addr;   // address of the most recently issued read
  logic [CNT_W-1:0] remaining;   // reads still to issue
  logic             inflight;    // a read was issued last cycle; data arrives now

  logic [WIDTH-1:0] fifo_data [2];
  logic [WIDTH-1:0] fifo_addr [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic [1:0]       fifo_count;

  logic             pop;
  logic [2:0]       occupancy;   // words buffered or in flight after this edge

  assign out_valid = (fifo_count != 2'd0);
  assign out_data  = fifo_data[rd_ptr];
  assign out_addr  = fifo_addr[rd_ptr];

  // Read issue: only when the FIFO can still hold the returning word.
  // NOTE: every signal gets a value on every path through always_comb,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    pop       = out_valid & out_ready;
    occupancy = {1'b0, fifo_count} + {2'b00, inflight} - {2'b00, pop};
    mem_re    = (state == READ) && (occupancy < 3'd2);
    mem_addr  = mem_re ? cur_addr : last_addr;
  end

  // Control FSM, address/count tracking and registered status outputs.
  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cur_addr  <= '0;
      last_addr <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err_align <= 1'b0;
    end else begin
      inflight <= mem_re;
      if (mem_re) begin
        cur_addr  <= cur_addr + WIDTH'(4);
        last_addr <= cur_addr;
        remaining <= remaining - CNT_W'(1);
      end
      case (state)
        IDLE: begin
          if (start) begin
            cur_addr  <= base_addr;
            remaining <= word_count;
            err_align <= 1'b0;
            if (base_addr[1:0] != 2'b00) begin
              err_align <= 1'b1;
              done      <= 1'b1;
              state     <= FIN;
            end else if (word_count == '0) begin
              done  <= 1'b1;
              state <= FIN;
            end else begin
              busy  <= 1'b1;
              state <= READ;
            end
          end
        end
        READ: begin
          if (mem_re && remaining == CNT_W'(1)) begin
            state <= DRAIN;
          end
        end
        DRAIN: begin
          // Finish on the edge that takes the final word out.
          if (occupancy == 3'd0) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end
        end
        FIN: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return FIFO: capture read data with its address, advance on handshake.
  // NOTE: the two storage entries are reset so out_data/out_addr read zero
  // out of reset; larger memories would normally be left unreset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_addr[i] <= '0;
      end
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      fifo_count <= 2'd0;
    end else begin
      if (inflight) begin
        fifo_data[wr_ptr] <= mem_rdata;
        fifo_addr[wr_ptr] <= last_addr;
        wr_ptr            <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      fifo_count <= fifo_count + {1'b0, inflight} - {1'b0, pop};
    end
  end

endmodule
